// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous prefetch FIFO of {pc, instr} entries; clear beats push and pop
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count,
    output fetch_entry_t head
);
    fetch_entry_t mem [DEPTH];
    logic [AW:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = count == (AW+1)'(DEPTH);
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential ICCM fetch with prefetch queue and flush redirect.
// Define IFU_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [31:0]   iccm_rd_addr,
    output logic          iccm_rd_en,
    input  logic [31:0]   iccm_rd_data,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr_location,
    output logic [31:0]   instr_to_dec,
    input  logic          flush_from_exe,
    input  logic [31:0]   flush_addr_exe,
    input  logic          flush_from_dec,
    input  logic [31:0]   flush_addr_dec,
    output logic [CW-1:0] fifo_count
);
    logic [31:0] fetch_pc, rsp_pc, target;
    logic inflight, flush, push, pop, empty, full, byp;
    logic [CW-1:0] count;
    fetch_entry_t head;

    assign flush  = flush_from_exe | flush_from_dec;
    assign target = (flush_from_exe ? flush_addr_exe : flush_addr_dec) & PC_ALIGN_MASK;
    // issue check counts the in-flight word so its response always has a slot
    assign iccm_rd_en   = !rst && !flush && (32'(count) + 32'(inflight) < FIFO_DEPTH);
    assign iccm_rd_addr = fetch_pc;

`ifdef IFU_BYPASS_EN
    assign byp = inflight && empty;
`else
    assign byp = 1'b0;
`endif

    assign instr_valid    = !rst && !flush && (!empty || byp);
    assign instr_location = byp ? rsp_pc : head.pc;
    assign instr_to_dec   = byp ? iccm_rd_data : head.instr;
    assign pop            = instr_valid && instr_ready && !empty;
    assign push           = inflight && !flush && !full && !(byp && instr_ready);
    assign fifo_count     = rst ? '0 : count;

    ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ('{pc: rsp_pc, instr: iccm_rd_data}),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC & PC_ALIGN_MASK;
            rsp_pc   <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            fetch_pc <= target;
            inflight <= 1'b0;
        end else begin
            inflight <= iccm_rd_en;
            if (iccm_rd_en) begin
                fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
                rsp_pc   <= fetch_pc;
            end
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scenarios plus random traffic against a queue-based fetch model
module tb_ifu_prefetch;
    localparam logic [31:0] RPC = 32'h100;
    localparam int D = 4;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, ready = 1'b1, fe = 1'b0, fd = 1'b0;
    logic [31:0] fae = '0, fad = '0, rd_data = '0;
    logic [31:0] addr, loc, ins;
    logic en, valid;
    logic [2:0] cnt;

    always #5 clk = ~clk;

    ifu_prefetch #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .iccm_rd_addr   (addr),
        .iccm_rd_en     (en),
        .iccm_rd_data   (rd_data),
        .instr_valid    (valid),
        .instr_ready    (ready),
        .instr_location (loc),
        .instr_to_dec   (ins),
        .flush_from_exe (fe),
        .flush_addr_exe (fae),
        .flush_from_dec (fd),
        .flush_addr_dec (fad),
        .fifo_count     (cnt)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    always @(posedge clk) rd_data <= memf(addr);

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: delivered stream is a queue of {pc, word}; one pending fetch; running pc
    logic [63:0] mq[$];
    bit mpend = 1'b0, mon = 1'b0;
    logic [31:0] mppc = '0, mpc = '0;
    logic [63:0] h;
    bit e, v, c;

    function automatic bit m_en();
        return !rst && !(fe || fd) && (mq.size() + int'(mpend) < D);
    endfunction
    function automatic bit m_valid();
        return !rst && !(fe || fd) && (mq.size() > 0 || (BYP && mpend));
    endfunction
    function automatic logic [63:0] m_head();
        return mq.size() > 0 ? mq[0] : {mppc, memf(mppc)};
    endfunction

    always @(negedge clk) begin
        e = m_en();
        v = m_valid();
        c = 1'b0;
        if (mon) begin
            chk("rd_en", 32'(en), 32'(e));
            if (e) chk("rd_addr", addr, mpc);
            chk("count", 32'(cnt), rst ? 32'd0 : 32'(mq.size()));
            chk("valid", 32'(valid), 32'(v));
            if (v) begin
                h = m_head();
                chk("location", loc, h[63:32]);
                chk("instr", ins, h[31:0]);
            end
        end
        if (rst) begin
            mq.delete();
            mpend = 1'b0;
            mpc = RPC;
            mon = 1'b1;
        end else if (fe || fd) begin
            mq.delete();
            mpend = 1'b0;
            mpc = (fe ? fae : fad) & 32'hFFFF_FFFC;
        end else begin
            if (v && ready) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else c = 1'b1;
            end
            if (mpend && !c) mq.push_back({mppc, memf(mppc)});
            mpend = e;
            if (e) begin
                mppc = mpc;
                mpc = mpc + 32'd4;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic nxt();
        @(negedge clk);
    endtask

    int n;
    initial begin
        // reset release with decode always ready
        repeat (3) cyc();
        rst = 1'b0;
        nxt(); chk("c0 addr", addr, 32'h100); chk("c0 en", 32'(en), 32'd1);
        cyc(); nxt(); chk("c1 addr", addr, 32'h104); chk("c1 valid", 32'(valid), 32'(BYP));
        cyc(); nxt(); chk("c2 addr", addr, 32'h108); chk("c2 valid", 32'(valid), 32'd1);
        chk("c2 loc", loc, BYP ? 32'h104 : 32'h100);
        cyc(); nxt(); chk("c3 loc", loc, BYP ? 32'h108 : 32'h104);

        // stall: exactly DEPTH issues, then drain in order
        cyc(); rst = 1'b1; ready = 1'b0;
        nxt(); chk("rst valid", 32'(valid), 32'd0); chk("rst count", 32'(cnt), 32'd0);
        cyc(); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            nxt();
            n += int'(en);
            if (i == 9) begin
                chk("stall count", 32'(cnt), 32'd4);
                chk("stall en", 32'(en), 32'd0);
            end
            cyc();
        end
        chk("stall issues", 32'(n), 32'd4);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nxt(); chk("drain loc", loc, 32'h100 + 32'(4 * k));
            cyc();
        end

        // decode flush with 3 queued and 1 in flight
        rst = 1'b1;
        cyc(); rst = 1'b0; ready = 1'b0;
        repeat (4) cyc();
        fd = 1'b1; fad = 32'h203;
        nxt(); chk("pre-flush count", 32'(cnt), 32'd3); chk("flush valid", 32'(valid), 32'd0);
        cyc(); fd = 1'b0; ready = 1'b1;
        nxt(); chk("flush addr", addr, 32'h200); chk("flush en", 32'(en), 32'd1);
        chk("flush+1 valid", 32'(valid), 32'd0);
        cyc(); nxt(); chk("flush+2 valid", 32'(valid), 32'(BYP));
        cyc(); nxt(); chk("flush+3 valid", 32'(valid), 32'd1);
        chk("flush+3 loc", loc, BYP ? 32'h204 : 32'h200);

        // simultaneous exe and dec flush
        cyc(); fe = 1'b1; fae = 32'h400; fd = 1'b1; fad = 32'h800;
        nxt();
        cyc(); fe = 1'b0; fd = 1'b0;
        nxt(); chk("exe prio addr", addr, 32'h400);

        // reset mid-stream with full queue
        cyc(); ready = 1'b0;
        repeat (8) cyc();
        nxt(); chk("full count", 32'(cnt), 32'd4);
        cyc(); rst = 1'b1;
        nxt(); chk("midrst valid", 32'(valid), 32'd0); chk("midrst count", 32'(cnt), 32'd0);
        cyc(); rst = 1'b0;
        nxt(); chk("post-rst count", 32'(cnt), 32'd0); chk("post-rst valid", 32'(valid), 32'd0);
        chk("post-rst addr", addr, RPC);

        // address wrap
        cyc(); fe = 1'b1; fae = 32'hFFFF_FFFC; ready = 1'b1;
        nxt();
        cyc(); fe = 1'b0;
        nxt(); chk("wrap addr0", addr, 32'hFFFF_FFFC);
        cyc(); nxt(); chk("wrap addr1", addr, 32'h0);
        cyc(); nxt(); chk("wrap loc0", loc, BYP ? 32'h0 : 32'hFFFF_FFFC);
        cyc(); nxt(); chk("wrap loc1", loc, BYP ? 32'h4 : 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            fe = $urandom_range(0, 49) == 0;
            fd = $urandom_range(0, 29) == 0;
            fae = $urandom;
            fad = $urandom;
            rst = $urandom_range(0, 199) == 0;
        end
        cyc(); rst = 1'b0; fe = 1'b0; fd = 1'b0; ready = 1'b1;
        repeat (5) cyc();
        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
